// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants, FSM state types and the frame
// checksum used by the UART command receiver.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 5;

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_RECOVER
    } byte_st_e;

    typedef enum logic [2:0] {
        P_WAIT_SYNC,
        P_GET_CMD,
        P_GET_DH,
        P_GET_DL,
        P_GET_CHK
    } parse_st_e;

    function automatic logic [7:0] frame_chk(
        input logic [7:0] cmd,
        input logic [7:0] dh,
        input logic [7:0] dl
    );
        return cmd ^ dh ^ dl;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-FF synchronizer plus 8N1 byte receiver.
// Ports: sys_clk, sys_rst (async, active-high), uart_rxd (serial in),
//   byte_vld (1-cycle strobe), byte_data[7:0] (valid with byte_vld),
//   frame_err (1-cycle strobe on low stop bit),
//   rx_idle (byte FSM idle; only with UART_CMD_TIMEOUT_EN).
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 139
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frame_err
`ifdef UART_CMD_TIMEOUT_EN
    ,
    output logic       rx_idle
`endif
);
    import uart_cmd_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rxs;
    logic          rxs_d;
    byte_st_e      st;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Idle-high line: synchronizer resets to 1 so reset release
    // never looks like a start edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st        <= B_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            unique case (st)
                B_IDLE: begin
                    if (rxs_d && !rxs) begin
                        st      <= B_START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                B_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        st  <= rxs ? B_IDLE : B_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                B_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            st <= B_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                B_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (rxs) begin
                            byte_vld <= 1'b1;
                            st       <= B_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            st        <= B_RECOVER;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                B_RECOVER: begin
                    if (rxs)
                        st <= B_IDLE;
                end
                default: st <= B_IDLE;
            endcase
        end
    end

    assign byte_data = shreg;

`ifdef UART_CMD_TIMEOUT_EN
    assign rx_idle = (st == B_IDLE);
`endif

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: parses 5-byte frames SYNC,CMD,DATA_H,DATA_L,CHK from
// the host UART. Optional inter-byte timeout: UART_CMD_TIMEOUT_EN.
// Ports: sys_clk, sys_rst (async, active-high), uart_rxd (serial in),
//   cmd_valid (1-cycle strobe), cmd_code[7:0], cmd_data[15:0]
//   (held until next cmd_valid), frame_err, chk_err (1-cycle strobes),
//   busy (parser is past SYNC).
module uart_cmd_rx #(
    parameter int         CLKS_PER_BIT = 139,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
`ifdef UART_CMD_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_BITS = 20
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rxd,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic        chk_err,
    output logic        busy
);
    import uart_cmd_pkg::*;

    logic       byte_vld;
    logic [7:0] byte_data;
    logic       drop;
    parse_st_e  pst;
    logic [7:0] cmd_q;
    logic [7:0] dh_q;
    logic [7:0] dl_q;

`ifdef UART_CMD_TIMEOUT_EN
    logic rx_idle;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .byte_vld (byte_vld),
        .byte_data(byte_data),
        .frame_err(frame_err)
`ifdef UART_CMD_TIMEOUT_EN
        ,
        .rx_idle  (rx_idle)
`endif
    );

    assign busy = (pst != P_WAIT_SYNC);

`ifdef UART_CMD_TIMEOUT_EN
    localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW        = $clog2(GAP_LIMIT + 1);

    logic [GW-1:0] gap;

    // Counts idle line time between bytes of an open frame; it holds
    // while a byte is being shifted in and restarts on each byte.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            gap <= '0;
        else if (byte_vld || !busy)
            gap <= '0;
        else if (rx_idle)
            gap <= gap + GW'(1);
    end

    assign drop = (gap == GW'(GAP_LIMIT));
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pst       <= P_WAIT_SYNC;
            cmd_q     <= '0;
            dh_q      <= '0;
            dl_q      <= '0;
            cmd_valid <= 1'b0;
            chk_err   <= 1'b0;
            cmd_code  <= '0;
            cmd_data  <= '0;
        end else begin
            cmd_valid <= 1'b0;
            chk_err   <= 1'b0;
            if (frame_err || drop) begin
                pst <= P_WAIT_SYNC;
            end else if (byte_vld) begin
                unique case (1'b1)
                    (pst == P_WAIT_SYNC): begin
                        if (byte_data == SYNC_BYTE)
                            pst <= P_GET_CMD;
                    end
                    (pst == P_GET_CMD): begin
                        cmd_q <= byte_data;
                        pst   <= P_GET_DH;
                    end
                    (pst == P_GET_DH): begin
                        dh_q <= byte_data;
                        pst  <= P_GET_DL;
                    end
                    (pst == P_GET_DL): begin
                        dl_q <= byte_data;
                        pst  <= P_GET_CHK;
                    end
                    (pst == P_GET_CHK): begin
                        if (byte_data == frame_chk(cmd_q, dh_q, dl_q)) begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= cmd_q;
                            cmd_data  <= {dh_q, dl_q};
                        end else begin
                            chk_err <= 1'b1;
                        end
                        pst <= P_WAIT_SYNC;
                    end
                    default: pst <= P_WAIT_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed plus randomized frames against a
// queue-based frame model; checks strobes, fields, busy, latency.
module tb_uart_cmd_rx;

    localparam int CPB = 139;

    logic        sys_clk;
    logic        sys_rst;
    logic        uart_rxd;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_data;
    logic        frame_err;
    logic        chk_err;
    logic        busy;

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_data (cmd_data),
        .frame_err(frame_err),
        .chk_err  (chk_err),
        .busy     (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cv = 0;
    int n_ce = 0;
    int n_fe = 0;
    int cv_cyc = 0;

    always @(negedge sys_clk) begin
        if (cmd_valid) begin
            n_cv   = n_cv + 1;
            cv_cyc = cyc;
        end
        if (chk_err)   n_ce = n_ce + 1;
        if (frame_err) n_fe = n_fe + 1;
    end

    int         checks = 0;
    int         errors = 0;
    int         t_start = 0;
    int         e_cv = 0;
    int         e_ce = 0;
    int         e_fe = 0;
    logic [7:0]  e_code = 8'h00;
    logic [15:0] e_data = 16'h0000;
    bit          in_frame = 0;
    logic [7:0]  fr[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(posedge sys_clk);
        #1;
        uart_rxd = 1'b0;
        t_start  = cyc;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            hold(CPB);
        end
        uart_rxd = !bad_stop;
        hold(CPB);
        uart_rxd = 1'b1;
        if (bad_stop) hold(CPB);
    endtask

    // Frame model: after SYNC, collect four bytes and judge the frame.
    task automatic model_byte(input logic [7:0] b, input bit bad_stop);
        logic [7:0] x;
        if (bad_stop) begin
            e_fe++;
            in_frame = 0;
            fr.delete();
        end else if (!in_frame) begin
            if (b == 8'hA5) in_frame = 1;
        end else begin
            fr.push_back(b);
            if (fr.size() == 4) begin
                x = fr[0] ^ fr[1] ^ fr[2];
                if (fr[3] == x) begin
                    e_cv++;
                    e_code = fr[0];
                    e_data = {fr[1], fr[2]};
                end else begin
                    e_ce++;
                end
                in_frame = 0;
                fr.delete();
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "/cmd_valid_cnt"}, n_cv, e_cv);
        check({tag, "/chk_err_cnt"}, n_ce, e_ce);
        check({tag, "/frame_err_cnt"}, n_fe, e_fe);
        check({tag, "/cmd_code"}, {24'h0, cmd_code}, {24'h0, e_code});
        check({tag, "/cmd_data"}, {16'h0, cmd_data}, {16'h0, e_data});
        check({tag, "/busy"}, {31'h0, busy}, {31'h0, in_frame});
    endtask

    task automatic xfer(input string tag, input logic [7:0] b,
                        input bit bad_stop);
        int prev_cv;
        prev_cv = e_cv;
        send_byte(b, bad_stop);
        model_byte(b, bad_stop);
        check_state(tag);
        if (e_cv != prev_cv)
            check({tag, "/latency"}, cv_cyc, t_start + 4 + CPB / 2 + 9 * CPB);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {cmd_valid, frame_err, chk_err, busy, cmd_code, cmd_data},
              32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, dh, dl, k, j;
        int bad_pos;

        sys_rst  = 1'b1;
        uart_rxd = 1'b1;
        hold(5);
        check_zero("reset");
        sys_rst = 1'b0;
        hold(20);
        check_state("post_reset");

        xfer("f1_sync", 8'hA5, 0);
        xfer("f1_cmd", 8'h01, 0);
        xfer("f1_dh", 8'h12, 0);
        xfer("f1_dl", 8'h34, 0);
        xfer("f1_chk", 8'h27, 0);

        xfer("f2_sync", 8'hA5, 0);
        xfer("f2_cmd", 8'h01, 0);
        xfer("f2_dh", 8'h12, 0);
        xfer("f2_dl", 8'h34, 0);
        xfer("f2_badchk", 8'h00, 0);

        xfer("f3_junk0", 8'h55, 0);
        xfer("f3_junk1", 8'hFF, 0);
        xfer("f3_sync", 8'hA5, 0);
        xfer("f3_cmd", 8'h02, 0);
        xfer("f3_dh", 8'h00, 0);
        xfer("f3_dl", 8'h10, 0);
        xfer("f3_chk", 8'h12, 0);

        xfer("f4_sync", 8'hA5, 0);
        xfer("f4_badstop", 8'h03, 1);
        xfer("f5_sync", 8'hA5, 0);
        xfer("f5_cmd", 8'h03, 0);
        xfer("f5_dh", 8'h00, 0);
        xfer("f5_dl", 8'h01, 0);
        xfer("f5_chk", 8'h02, 0);

        uart_rxd = 1'b0;
        hold(30);
        uart_rxd = 1'b1;
        hold(3 * CPB);
        check_state("glitch");

        xfer("rst_sync", 8'hA5, 0);
        xfer("rst_cmd", 8'h01, 0);
        @(posedge sys_clk);
        #1;
        uart_rxd = 1'b0;
        hold(3 * CPB);
        sys_rst = 1'b1;
        hold(2);
        check_zero("in_reset");
        uart_rxd = 1'b1;
        hold(10);
        check_zero("in_reset_late");
        sys_rst  = 1'b0;
        in_frame = 0;
        fr.delete();
        e_code = 8'h00;
        e_data = 16'h0000;
        hold(2 * CPB);
        check_zero("after_reset");
        check_state("after_reset");

        xfer("to_sync", 8'hA5, 0);
        xfer("to_cmd", 8'h04, 0);
        hold(25 * CPB);
`ifdef UART_CMD_TIMEOUT_EN
        in_frame = 0;
        fr.delete();
`endif
        check("to_busy", {31'h0, busy}, {31'h0, in_frame});
        xfer("to_dh", 8'h00, 0);
        xfer("to_dl", 8'h01, 0);
        xfer("to_chk", 8'h05, 0);

        for (int f = 0; f < 2; f++) begin
            if ($urandom_range(1, 0) == 1) begin
                j = 8'($urandom_range(255, 0));
                xfer("rnd_junk", j, 0);
            end
            c  = 8'($urandom_range(255, 0));
            dh = 8'($urandom_range(255, 0));
            dl = 8'($urandom_range(255, 0));
            k  = c ^ dh ^ dl;
            if ($urandom_range(3, 0) == 0)
                k = k ^ 8'(1 << $urandom_range(7, 0));
            bad_pos = ($urandom_range(5, 0) == 0) ? $urandom_range(4, 1) : 0;
            xfer("rnd_sync", 8'hA5, 0);
            xfer("rnd_cmd", c, bad_pos == 1);
            xfer("rnd_dh", dh, bad_pos == 2);
            xfer("rnd_dl", dl, bad_pos == 3);
            xfer("rnd_chk", k, bad_pos == 4);
        end

        hold(CPB);
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
